// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between fetch and the program loader; 1-cycle read latency.
// Grants are combinational. A denied requester simply retries. Loader LOCK mode freezes fetch.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, LOCK_PEND, LOCK} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_LD} tag_t;

  state_t            state, state_nxt;
  tag_t              tag, tag_nxt;
  logic              tag_oor, tag_oor_nxt;
  logic [WC_W-1:0]   wait_cnt, wait_nxt;
  logic [DATA_W-1:0] if_rdata_q, ld_rdata_q;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;
  logic [DATA_W-1:0] rdata_src;

  // State register and all sequential bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      tag        <= TAG_NONE;
      tag_oor    <= 1'b0;
      wait_cnt   <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      tag      <= tag_nxt;
      tag_oor  <= tag_oor_nxt;
      wait_cnt <= wait_nxt;
      if (tag == TAG_IF) if_rdata_q <= rdata_src;
      if (tag == TAG_LD) ld_rdata_q <= rdata_src;
    end
  end

  // Next-state logic. LOCK_PEND never grants, so any read still in flight
  // returns during that cycle and the tag is guaranteed empty on exit.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (ld_lock) state_nxt = LOCK_PEND;
      LOCK_PEND: begin
        if (!ld_lock)                  state_nxt = RUN;
        else if (tag_nxt == TAG_NONE)  state_nxt = LOCK;
      end
      LOCK:      if (!ld_lock) state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // Output logic: grants. Fetch only beats a contending loader once starved MAX_WAIT cycles.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (if_req && (!ld_req || wait_cnt == WC_W'(MAX_WAIT))) if_gnt = 1'b1;
          else if (ld_req)                                        ld_gnt = 1'b1;
        end
        LOCK:    ld_gnt = ld_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_addr  = ld_gnt ? ld_addr : if_addr;
    in_range  = (sel_addr < ADDR_W'(DEPTH));
    mem_en    = (if_gnt | ld_gnt) & in_range;
    mem_we    = ld_gnt & ld_we & in_range;
    mem_addr  = sel_addr;
    mem_wdata = ld_wdata;
  end

  always_comb begin
    tag_nxt     = TAG_NONE;
    tag_oor_nxt = !in_range;
    if (if_gnt)               tag_nxt = TAG_IF;
    else if (ld_gnt && !ld_we) tag_nxt = TAG_LD;
  end

  always_comb begin
    if (!if_req || if_gnt)              wait_nxt = '0;
    else if (wait_cnt != WC_W'(MAX_WAIT)) wait_nxt = wait_cnt + WC_W'(1);
    else                                wait_nxt = wait_cnt;
  end

  // Out-of-range reads never touched memory, so they return zero instead of mem_rdata.
  always_comb begin
    rdata_src = tag_oor ? '0 : mem_rdata;
    if_rvalid = rst && (tag == TAG_IF);
    ld_rvalid = rst && (tag == TAG_LD);
    locked    = rst && (state == LOCK);
    if (!rst)           if_rdata = '0;
    else if (if_rvalid) if_rdata = rdata_src;
    else                if_rdata = if_rdata_q;
    if (!rst)           ld_rdata = '0;
    else if (ld_rvalid) ld_rdata = rdata_src;
    else                ld_rdata = ld_rdata_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 128-word synchronous-read memory model behind it.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req, ld_we, ld_lock;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        locked;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Low address bits only, so an out-of-range access that leaks through aliases and gets noticed.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[6:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then set and outputs checked 1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i;
    mem_rdata = '0;
    rst = 1'b0; if_req = 1'b1; if_addr = '0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd2; ld_wdata = '0; ld_lock = 1'b0;

    // Reset with both requesting
    #2;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_ld_rvalid", ld_rvalid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_if_rdata", if_rdata, 0);
    cyc(); rst = 1'b1; #1;
    chk("post_rst_ld_gnt", ld_gnt, 1);
    chk("post_rst_if_gnt", if_gnt, 0);
    cyc(); if_req = 1'b0; ld_req = 1'b0; #1;
    chk("post_rst_ld_rvalid", ld_rvalid, 1);
    chk("post_rst_ld_rdata", ld_rdata, 2);

    // Fetch stream
    for (int i = 0; i < 10; i++) begin
      cyc(); if_req = 1'b1; if_addr = i; #1;
      chk("fetch_gnt", if_gnt, 1);
      chk("fetch_mem_addr", mem_addr, i);
      if (i > 0) begin
        chk("fetch_rvalid", if_rvalid, 1);
        chk("fetch_rdata", if_rdata, i - 1);
      end
    end
    cyc(); if_req = 1'b0; #1;
    chk("fetch_last_rvalid", if_rvalid, 1);
    chk("fetch_last_rdata", if_rdata, 9);
    chk("fetch_idle_gnt", if_gnt, 0);

    // Contention: loader 4 grants, then fetch forced through
    for (int k = 0; k < 15; k++) begin
      cyc(); if_req = 1'b1; if_addr = 32'd30; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd20; #1;
      chk("cont_if_gnt", if_gnt, (k % 5) == 4);
      chk("cont_ld_gnt", ld_gnt, (k % 5) != 4);
      if (k > 0) begin
        chk("cont_if_rvalid", if_rvalid, ((k - 1) % 5) == 4);
        chk("cont_ld_rvalid", ld_rvalid, ((k - 1) % 5) != 4);
        if (((k - 1) % 5) != 4) chk("cont_ld_rdata", ld_rdata, 20);
      end
    end
    cyc(); if_req = 1'b0; ld_req = 1'b0; #1;
    chk("cont_end_if_rvalid", if_rvalid, 1);
    chk("cont_end_if_rdata", if_rdata, 30);

    // Lock entry with a fetch read in flight
    cyc(); if_req = 1'b1; if_addr = 32'd3; ld_lock = 1'b1; #1;
    chk("lock_fetch_gnt", if_gnt, 1);
    chk("lock_pre_locked", locked, 0);
    cyc(); ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd5; #1;
    chk("pend_if_gnt", if_gnt, 0);
    chk("pend_ld_gnt", ld_gnt, 0);
    chk("pend_if_rvalid", if_rvalid, 1);
    chk("pend_if_rdata", if_rdata, 3);
    chk("pend_locked", locked, 0);
    cyc(); ld_we = 1'b1; ld_wdata = 32'hDEADBEEF; #1;
    chk("lock_locked", locked, 1);
    chk("lock_wr_gnt", ld_gnt, 1);
    chk("lock_wr_if_gnt", if_gnt, 0);
    chk("lock_wr_mem_we", mem_we, 1);
    cyc(); ld_we = 1'b0; #1;
    chk("lock_rd_gnt", ld_gnt, 1);
    chk("lock_rd_if_gnt", if_gnt, 0);
    chk("lock_wr_no_rvalid", ld_rvalid, 0);
    cyc(); ld_req = 1'b0; ld_lock = 1'b0; #1;
    chk("lock_rd_rvalid", ld_rvalid, 1);
    chk("lock_rd_rdata", ld_rdata, 32'hDEADBEEF);
    chk("lock_hold_locked", locked, 1);
    chk("lock_hold_if_gnt", if_gnt, 0);
    cyc(); #1;
    chk("unlock_locked", locked, 0);
    chk("unlock_if_gnt", if_gnt, 1);

    // Out-of-range accesses
    cyc(); if_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'd200; #1;
    chk("oor_rd_gnt", ld_gnt, 1);
    chk("oor_rd_mem_en", mem_en, 0);
    cyc(); ld_we = 1'b1; ld_addr = 32'd128; ld_wdata = 32'h12345678; #1;
    chk("oor_rd_rvalid", ld_rvalid, 1);
    chk("oor_rd_rdata", ld_rdata, 0);
    chk("oor_wr_gnt", ld_gnt, 1);
    chk("oor_wr_mem_en", mem_en, 0);
    chk("oor_wr_mem_we", mem_we, 0);
    cyc(); ld_we = 1'b0; ld_addr = 32'd127; #1;
    chk("top_addr_mem_en", mem_en, 1);
    chk("oor_wr_no_rvalid", ld_rvalid, 0);
    cyc(); ld_addr = 32'd0; #1;
    chk("top_addr_rdata", ld_rdata, 127);
    cyc(); ld_req = 1'b0; #1;
    chk("addr0_rvalid", ld_rvalid, 1);
    chk("addr0_unchanged", ld_rdata, 0);

    // Reset in the middle of a fetch read
    cyc(); if_req = 1'b1; if_addr = 32'd7; #1;
    chk("midrst_gnt", if_gnt, 1);
    cyc(); rst = 1'b0; if_req = 1'b0; #1;
    chk("midrst_rvalid_in_rst", if_rvalid, 0);
    chk("midrst_gnt_in_rst", if_gnt, 0);
    cyc(); rst = 1'b1; #1;
    chk("midrst_rvalid_after", if_rvalid, 0);
    chk("midrst_rdata_cleared", if_rdata, 0);
    cyc(); #1;
    chk("midrst_rvalid_later", if_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
